clk_sel_ctrl: RTL and testbench

Select sequencer that sits directly upstream of the glitch-free clock mux (`glitch_free`) and drives its `select` input. It accepts switch requests, refuses to switch onto `clk1` unless `clk1` is seen toggling, and holds `select` stable for a settle period so the mux can complete its handover. It then enforces a minimum dwell time before accepting the next switch, and falls back to `clk0` automatically if `clk1` dies while selected. The block runs entirely on `clk0`, the always-running reference clock.

---
 rtl/clk_sel_ctrl.sv | 142 ++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
`timescale 1ns / 1ps
// Select sequencer for the glitch-free clock mux. It checks clk1 liveness, holds select through a
// settle period and a dwell period, and falls back to clk0 when clk1 dies. Everything runs on clk0.
module clk_sel_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES  = 32,
  parameter int unsigned ALIVE_WINDOW  = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk0,
  input  logic rst_n,
  input  logic req,
  input  logic req_sel,
  input  logic clk1_tog,
  output logic select,
  output logic busy,
  output logic done,
  output logic err,
  output logic clk1_alive
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DWELL  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALIVE_MAX   = CNT_W'(ALIVE_WINDOW);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [2:0]       tog_sync_q;
  logic             select_q, select_d;
  logic             tgt_q, tgt_d;
  logic             fb_q, fb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tog_edge;

  // Two flops resynchronize clk1_tog; the third one only delays it for edge detection.
  assign tog_edge   = tog_sync_q[1] ^ tog_sync_q[2];
  assign clk1_alive = (acnt_q < ALIVE_MAX);

  always_comb begin
    acnt_d = acnt_q;
    if (tog_edge)                acnt_d = '0;
    else if (acnt_q < ALIVE_MAX) acnt_d = acnt_q + CNT_W'(1);
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    tgt_d    = tgt_q;
    fb_d     = fb_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A dead clk1 under select forces a return to clk0 and drops any request in this cycle.
        if (select_q && !clk1_alive) begin
          err_d   = 1'b1;
          tgt_d   = 1'b0;
          fb_d    = 1'b1;
          state_d = SWITCH;
        end else if (req) begin
          if (req_sel == select_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = req_sel;
            state_d = req_sel ? CHECK : SWITCH;
          end
        end
      end
      CHECK: begin
        if (clk1_alive) begin
          state_d = SWITCH;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SWITCH: begin
        select_d = tgt_q;
        cnt_d    = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = DWELL_LOAD;
          done_d  = !fb_q;
          fb_d    = 1'b0;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DWELL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acnt_q     <= ALIVE_MAX;
      tog_sync_q <= '0;
      select_q   <= 1'b0;
      tgt_q      <= 1'b0;
      fb_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acnt_q     <= acnt_d;
      tog_sync_q <= {tog_sync_q[1:0], clk1_tog};
      select_q   <= select_d;
      tgt_q      <= tgt_d;
      fb_q       <= fb_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign select = select_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
`timescale 1ns / 1ps
// Directed bench for clk_sel_ctrl with default parameters: clk0 period 4 ns, clk1_tog toggling
// every 5 ns on a half-ns offset so it never lands on a clk0 edge.
module tb_clk_sel_ctrl;

  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic req_sel = 1'b0;
  logic clk1_tog = 1'b0;
  logic tog_en = 1'b0;
  logic select, busy, done, err, clk1_alive;

  int n_tests = 0;
  int n_fail  = 0;

  clk_sel_ctrl #(
    .SETTLE_CYCLES(16),
    .DWELL_CYCLES (32),
    .ALIVE_WINDOW (64),
    .CNT_W        (8)
  ) dut (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .req       (req),
    .req_sel   (req_sel),
    .clk1_tog  (clk1_tog),
    .select    (select),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .clk1_alive(clk1_alive)
  );

  always #2 clk0 = ~clk0;

  initial begin
    #2.5;
    forever begin
      #5;
      if (tog_en) clk1_tog = ~clk1_tog;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after the next clk0 rising edge; all sampling and driving happens there.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic wait_alive(input string name);
    for (int i = 0; i < 20 && !clk1_alive; i++) step(1);
    n_tests++;
    if (clk1_alive !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: clk1_alive=%b required 1 within 20 cycles", name, clk1_alive);
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    step(3);
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_values: {sel,busy,done,err,alive}=%b required 00000", obs);
    end
    rst_n = 1'b1;
    step(10);
    req = 1'b1; req_sel = 1'b1;
    step(1);
    req = 1'b0; req_sel = 1'b0;
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b01000) begin
      n_fail++;
      $display("FAIL refused_check_cycle: {sel,busy,done,err,alive}=%b required 01000", obs);
    end
    step(1);
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b00010) begin
      n_fail++;
      $display("FAIL refused_err: {sel,busy,done,err,alive}=%b required 00010", obs);
    end
    step(1);
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL refused_after: {sel,busy,done,err,alive}=%b required 00000", obs);
    end
  endtask

  task automatic test_same_target();
    logic [3:0] obs;
    req = 1'b1; req_sel = 1'b0;
    step(1);
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      obs = {select, busy, done, err};
      n_tests++;
      if (obs !== {1'b0, 1'b0, (k == 1), 1'b0}) begin
        n_fail++;
        $display("FAIL same_target N+%0d: {sel,busy,done,err}=%b required %b",
                 k, obs, {1'b0, 1'b0, (k == 1), 1'b0});
      end
      step(1);
    end
  endtask

  task automatic test_switch_to_clk1();
    logic [3:0] obs, exp;
    tog_en = 1'b1;
    wait_alive("to_clk1_alive");
    step(2);
    req = 1'b1; req_sel = 1'b1;
    step(1);
    req = 1'b0; req_sel = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      exp = {(k >= 3), (k <= 50), (k == 19), 1'b0};
      obs = {select, busy, done, err};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL to_clk1 N+%0d: {sel,busy,done,err}=%b required %b", k, obs, exp);
      end
      step(1);
    end
  endtask

  task automatic test_switch_to_clk0();
    logic [3:0] obs, exp;
    req = 1'b1; req_sel = 1'b0;
    step(1);
    req = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      exp = {(k < 2), (k <= 49), (k == 18), 1'b0};
      obs = {select, busy, done, err};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL to_clk0 N+%0d: {sel,busy,done,err}=%b required %b", k, obs, exp);
      end
      // A request during DWELL must be ignored without error or queueing.
      req     = (k == 20);
      req_sel = (k == 20);
      step(1);
    end
    req = 1'b0; req_sel = 1'b0;
  endtask

  task automatic test_fallback();
    logic [3:0] obs, exp;
    int c;
    req = 1'b1; req_sel = 1'b1;
    step(1);
    req = 1'b0; req_sel = 1'b0;
    step(52);
    n_tests++;
    if ({select, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL fallback_setup: {sel,busy}=%b required 10", {select, busy});
    end
    tog_en = 1'b0;
    c = 0;
    while (clk1_alive && c < 100) begin
      step(1);
      c++;
    end
    n_tests++;
    if (c < 62 || c > 70) begin
      n_fail++;
      $display("FAIL alive_timeout: alive fell after %0d cycles, required 62..70", c);
      return;
    end
    for (int k = 0; k <= 52; k++) begin
      exp = {(k < 2), (k >= 1 && k <= 49), 1'b0, (k == 1)};
      obs = {select, busy, done, err};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL fallback M+%0d: {sel,busy,done,err}=%b required %b", k, obs, exp);
      end
      step(1);
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [4:0] obs;
    tog_en = 1'b1;
    wait_alive("mid_settle_alive");
    step(2);
    req = 1'b1; req_sel = 1'b1;
    step(1);
    req = 1'b0; req_sel = 1'b0;
    step(7);
    n_tests++;
    if ({select, busy, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_settle_state: {sel,busy,done}=%b required 110", {select, busy, done});
    end
    tog_en   = 1'b0;
    clk1_tog = 1'b0;
    rst_n    = 1'b0;
    #1;
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: {sel,busy,done,err,alive}=%b required 00000", obs);
    end
    step(2);
    rst_n = 1'b1;
    step(6);
    obs = {select, busy, done, err, clk1_alive};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_dead: {sel,busy,done,err,alive}=%b required 00000", obs);
    end
    tog_en = 1'b1;
    step(8);
    n_tests++;
    if (clk1_alive !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_revive: clk1_alive=%b required 1", clk1_alive);
    end
  endtask

  initial begin
    test_reset();
    test_same_target();
    test_switch_to_clk1();
    test_switch_to_clk0();
    test_fallback();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
